// File: rtl/fsm_ctrl_pkg.sv
// fsm_ctrl_pkg: FSM state codes and input conditioner defaults shared across the control path
package fsm_ctrl_pkg;
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } fsm_state_e;
  localparam int DEBOUNCE_DEF = 4;
endpackage

// File: rtl/db_channel.sv
// db_channel: two-flop synchroniser plus debounce counter for one raw control line
module db_channel import fsm_ctrl_pkg::*; #(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic q,
  output logic upd,
  output logic rej
);
  logic       s1;
  logic       s2;
  logic       mis;
  logic [7:0] cnt;
  // upd fires on the edge q takes s2; rej fires when a partial run collapses without qualifying
  always_comb begin
    mis = s2 != q;
    upd = mis && cnt == 8'(DEBOUNCE - 1);
    rej = !mis && cnt != 8'd0;
  end
  // synchronise, count consecutive mismatches, follow s2 once it has held long enough
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= 8'd0;
      q   <= 1'b0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      cnt <= (upd || !mis) ? 8'd0 : cnt + 8'd1;
      q   <= upd ? s2 : q;
    end
  end
endmodule

// File: rtl/fsm_xz_conditioner.sv
// fsm_xz_conditioner: debounced, synchronous x/z levels for the FSM decode, with change pulse and glitch count
module fsm_xz_conditioner import fsm_ctrl_pkg::*; #(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int GW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          x_raw,
  input  logic          z_raw,
  output logic          x,
  output logic          z,
  output logic          xz_chg,
  output logic [GW-1:0] glitch_cnt
);
  logic x_upd;
  logic z_upd;
  logic x_rej;
  logic z_rej;
  db_channel #(.DEBOUNCE(DEBOUNCE)) u_x (
    .clk (clk),
    .rst (rst),
    .raw (x_raw),
    .q   (x),
    .upd (x_upd),
    .rej (x_rej)
  );
  db_channel #(.DEBOUNCE(DEBOUNCE)) u_z (
    .clk (clk),
    .rst (rst),
    .raw (z_raw),
    .q   (z),
    .upd (z_upd),
    .rej (z_rej)
  );
  // one pulse per updating edge; one glitch count per rejecting edge, held at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xz_chg     <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      xz_chg     <= x_upd || z_upd;
      glitch_cnt <= ((x_rej || z_rej) && !(&glitch_cnt)) ? glitch_cnt + GW'(1) : glitch_cnt;
    end
  end
endmodule
